// File: rtl/rx_cmd_parser_pkg.sv
// rx_cmd_parser_pkg
// Shared definitions for the receive-path command parser:
//   - command opcode byte values
//   - parser state encoding
//   - register-file addresses that receive the ALU operands
package rx_cmd_parser_pkg;

    localparam logic [7:0] OPC_WRITE   = 8'hAA;  // AA, ADDR, DATA
    localparam logic [7:0] OPC_READ    = 8'hBB;  // BB, ADDR
    localparam logic [7:0] OPC_ALU_OP  = 8'hCC;  // CC, OPA, OPB, FUN
    localparam logic [7:0] OPC_ALU_NOP = 8'hDD;  // DD, FUN

    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_ALU_OPA,
        ST_ALU_OPB,
        ST_ALU_FUN
    } state_t;

endpackage

// File: rtl/rx_cmd_timeout.sv
// rx_cmd_timeout
// Inter-byte watchdog for the command parser. Counts cycles while enabled
// and no byte arrives; pulses expire on the TIMEOUT_CYCLES-th such cycle.
// Ports:
//   CLK     system clock
//   RST     synchronous active-low reset
//   en      count enable (parser holds a partial command)
//   clr     an accepted byte restarts the count
//   expire  combinational, high on the cycle the limit is reached
module rx_cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic CLK,
    input  logic RST,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    // cnt holds the number of already-elapsed silent cycles, so the current
    // cycle is number cnt+1; expiry is flagged on the last one so the parser
    // can register CMD_ERR on the same edge that ends it.
    assign expire = en && !clr && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt <= '0;
        end else if (!en || clr || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rx_cmd_parser.sv
// rx_cmd_parser
// Assembles validated UART bytes into register-file read/write and ALU
// commands. Strobes are single-cycle; address, write data and function code
// are held until the next strobe that updates them.
// Optional feature macro: RX_CMD_TIMEOUT_EN adds an inter-byte timeout that
// aborts a partial command after TIMEOUT_CYCLES cycles without a byte.
// Ports:
//   CLK, RST               clock, synchronous active-low reset
//   RX_P_DATA, RX_D_VLD    received byte and its valid strobe
//   RX_PAR_ERR, RX_FRM_ERR receiver parity / framing error flags
//   RF_WrEn, RF_RdEn       register-file write / read strobes
//   RF_Address, RF_WrData  register-file address and write data (held)
//   ALU_EN, ALU_FUN        ALU strobe and function code (held)
//   CMD_BUSY               a command is partially assembled
//   CMD_ERR                one-cycle pulse on an aborted or illegal command
module rx_cmd_parser
    import rx_cmd_parser_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  RX_PAR_ERR,
    input  logic                  RX_FRM_ERR,
    output logic                  RF_WrEn,
    output logic                  RF_RdEn,
    output logic [ADDR_WIDTH-1:0] RF_Address,
    output logic [DATA_WIDTH-1:0] RF_WrData,
    output logic                  ALU_EN,
    output logic [3:0]            ALU_FUN,
    output logic                  CMD_BUSY,
    output logic                  CMD_ERR
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_hold;
    logic                  rx_err;
    logic                  byte_ok;
    logic                  addr_bad;
    logic                  fun_bad;
    logic                  timeout_hit;

    assign rx_err   = RX_PAR_ERR || RX_FRM_ERR;
    // A byte arriving together with an error flag is never used.
    assign byte_ok  = RX_D_VLD && !rx_err;
    assign addr_bad = (RX_P_DATA >> ADDR_WIDTH) != '0;
    assign fun_bad  = (RX_P_DATA >> 4) != '0;
    assign CMD_BUSY = (state != ST_IDLE);

`ifdef RX_CMD_TIMEOUT_EN
    rx_cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .CLK   (CLK),
        .RST   (RST),
        .en    (state != ST_IDLE),
        .clr   (byte_ok),
        .expire(timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= ST_IDLE;
            addr_hold  <= '0;
            RF_WrEn    <= 1'b0;
            RF_RdEn    <= 1'b0;
            RF_Address <= '0;
            RF_WrData  <= '0;
            ALU_EN     <= 1'b0;
            ALU_FUN    <= '0;
            CMD_ERR    <= 1'b0;
        end else begin
            RF_WrEn <= 1'b0;
            RF_RdEn <= 1'b0;
            ALU_EN  <= 1'b0;
            CMD_ERR <= 1'b0;
            // Abort has priority; once back in IDLE a persisting flag is
            // ignored, so it yields exactly one CMD_ERR.
            if (state != ST_IDLE && (rx_err || timeout_hit)) begin
                CMD_ERR <= 1'b1;
                state   <= ST_IDLE;
            end else if (byte_ok) begin
                case (state)
                    ST_IDLE: begin
                        case (RX_P_DATA)
                            DATA_WIDTH'(OPC_WRITE):   state <= ST_WR_ADDR;
                            DATA_WIDTH'(OPC_READ):    state <= ST_RD_ADDR;
                            DATA_WIDTH'(OPC_ALU_OP):  state <= ST_ALU_OPA;
                            DATA_WIDTH'(OPC_ALU_NOP): state <= ST_ALU_FUN;
                            default:                  CMD_ERR <= 1'b1;
                        endcase
                    end
                    ST_WR_ADDR: begin
                        if (addr_bad) begin
                            CMD_ERR <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            // RF_Address is only updated with the strobe.
                            addr_hold <= RX_P_DATA[ADDR_WIDTH-1:0];
                            state     <= ST_WR_DATA;
                        end
                    end
                    ST_WR_DATA: begin
                        RF_WrEn    <= 1'b1;
                        RF_Address <= addr_hold;
                        RF_WrData  <= RX_P_DATA;
                        state      <= ST_IDLE;
                    end
                    ST_RD_ADDR: begin
                        if (addr_bad) begin
                            CMD_ERR <= 1'b1;
                        end else begin
                            RF_RdEn    <= 1'b1;
                            RF_Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                        end
                        state <= ST_IDLE;
                    end
                    ST_ALU_OPA: begin
                        RF_WrEn    <= 1'b1;
                        RF_Address <= ADDR_WIDTH'(OPA_ADDR);
                        RF_WrData  <= RX_P_DATA;
                        state      <= ST_ALU_OPB;
                    end
                    ST_ALU_OPB: begin
                        RF_WrEn    <= 1'b1;
                        RF_Address <= ADDR_WIDTH'(OPB_ADDR);
                        RF_WrData  <= RX_P_DATA;
                        state      <= ST_ALU_FUN;
                    end
                    ST_ALU_FUN: begin
                        if (fun_bad) begin
                            CMD_ERR <= 1'b1;
                        end else begin
                            ALU_EN  <= 1'b1;
                            ALU_FUN <= RX_P_DATA[3:0];
                        end
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_cmd_parser.sv
// tb_rx_cmd_parser
// Directed bench for rx_cmd_parser. Inputs change on the falling edge, so the
// response to a byte is sampled on the following falling edge.
// The flags vector packs {RF_WrEn, RF_RdEn, ALU_EN, CMD_ERR, CMD_BUSY}.
module tb_rx_cmd_parser;

    localparam int DATA_WIDTH     = 8;
    localparam int ADDR_WIDTH     = 4;
    localparam int TIMEOUT_CYCLES = 16;

    logic                  CLK = 1'b0;
    logic                  RST = 1'b0;
    logic [DATA_WIDTH-1:0] RX_P_DATA = '0;
    logic                  RX_D_VLD = 1'b0;
    logic                  RX_PAR_ERR = 1'b0;
    logic                  RX_FRM_ERR = 1'b0;
    logic                  RF_WrEn;
    logic                  RF_RdEn;
    logic [ADDR_WIDTH-1:0] RF_Address;
    logic [DATA_WIDTH-1:0] RF_WrData;
    logic                  ALU_EN;
    logic [3:0]            ALU_FUN;
    logic                  CMD_BUSY;
    logic                  CMD_ERR;

    logic [4:0] flags;
    assign flags = {RF_WrEn, RF_RdEn, ALU_EN, CMD_ERR, CMD_BUSY};

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    rx_cmd_parser #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDR_WIDTH    (ADDR_WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_P_DATA (RX_P_DATA),
        .RX_D_VLD  (RX_D_VLD),
        .RX_PAR_ERR(RX_PAR_ERR),
        .RX_FRM_ERR(RX_FRM_ERR),
        .RF_WrEn   (RF_WrEn),
        .RF_RdEn   (RF_RdEn),
        .RF_Address(RF_Address),
        .RF_WrData (RF_WrData),
        .ALU_EN    (ALU_EN),
        .ALU_FUN   (ALU_FUN),
        .CMD_BUSY  (CMD_BUSY),
        .CMD_ERR   (CMD_ERR)
    );

    // Called at a falling edge; returns at the next falling edge.
    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (flags !== 5'b00000) begin
            errors++; $display("FAIL reset_flags got %b exp %b", flags, 5'b00000);
        end
        checks++;
        if ({RF_Address, RF_WrData, ALU_FUN} !== 16'h0000) begin
            errors++; $display("FAIL reset_fields got %h exp %h", {RF_Address, RF_WrData, ALU_FUN}, 16'h0000);
        end
        RST = 1'b1;
        idle_cycle();
    endtask

    task automatic test_write();
        send_byte(8'hAA);
        checks++;
        if (flags !== 5'b00001) begin
            errors++; $display("FAIL wr_opcode flags got %b exp %b", flags, 5'b00001);
        end
        send_byte(8'h05);
        checks++;
        if (flags !== 5'b00001) begin
            errors++; $display("FAIL wr_addr flags got %b exp %b", flags, 5'b00001);
        end
        send_byte(8'h3C);
        checks++;
        if (flags !== 5'b10000) begin
            errors++; $display("FAIL wr_strobe flags got %b exp %b", flags, 5'b10000);
        end
        checks++;
        if ({RF_Address, RF_WrData} !== 12'h53C) begin
            errors++; $display("FAIL wr_fields got %h exp %h", {RF_Address, RF_WrData}, 12'h53C);
        end
        idle_cycle();
        checks++;
        if (flags !== 5'b00000 || RF_Address !== 4'h5) begin
            errors++; $display("FAIL wr_after flags %b addr %h exp %b %h", flags, RF_Address, 5'b00000, 4'h5);
        end
    endtask

    task automatic test_read();
        send_byte(8'hBB);
        send_byte(8'h0F);
        checks++;
        if (flags !== 5'b01000 || RF_Address !== 4'hF) begin
            errors++; $display("FAIL rd_strobe flags %b addr %h exp %b %h", flags, RF_Address, 5'b01000, 4'hF);
        end
        idle_cycle();
        checks++;
        if (flags !== 5'b00000) begin
            errors++; $display("FAIL rd_after flags got %b exp %b", flags, 5'b00000);
        end
        send_byte(8'hBB);
        send_byte(8'h10);
        checks++;
        if (flags !== 5'b00010 || RF_Address !== 4'hF) begin
            errors++; $display("FAIL rd_badaddr flags %b addr %h exp %b %h", flags, RF_Address, 5'b00010, 4'hF);
        end
        idle_cycle();
        checks++;
        if (flags !== 5'b00000) begin
            errors++; $display("FAIL rd_badaddr_after flags got %b exp %b", flags, 5'b00000);
        end
    endtask

    // Opcodes follow completing bytes with no gap throughout.
    task automatic test_back_to_back_alu();
        send_byte(8'hCC);
        send_byte(8'h12);
        checks++;
        if (flags !== 5'b10001 || {RF_Address, RF_WrData} !== 12'h012) begin
            errors++; $display("FAIL alu_opa flags %b fields %h exp %b %h", flags, {RF_Address, RF_WrData}, 5'b10001, 12'h012);
        end
        send_byte(8'h34);
        checks++;
        if (flags !== 5'b10001 || {RF_Address, RF_WrData} !== 12'h134) begin
            errors++; $display("FAIL alu_opb flags %b fields %h exp %b %h", flags, {RF_Address, RF_WrData}, 5'b10001, 12'h134);
        end
        send_byte(8'h03);
        checks++;
        if (flags !== 5'b00100 || ALU_FUN !== 4'h3) begin
            errors++; $display("FAIL alu_fun flags %b fun %h exp %b %h", flags, ALU_FUN, 5'b00100, 4'h3);
        end
        send_byte(8'hDD);
        checks++;
        if (flags !== 5'b00001 || ALU_FUN !== 4'h3) begin
            errors++; $display("FAIL alu_dd_opcode flags %b fun %h exp %b %h", flags, ALU_FUN, 5'b00001, 4'h3);
        end
        send_byte(8'h07);
        checks++;
        if (flags !== 5'b00100 || ALU_FUN !== 4'h7) begin
            errors++; $display("FAIL alu_dd_fun flags %b fun %h exp %b %h", flags, ALU_FUN, 5'b00100, 4'h7);
        end
        send_byte(8'hDD);
        send_byte(8'h17);
        checks++;
        if (flags !== 5'b00010 || ALU_FUN !== 4'h7) begin
            errors++; $display("FAIL alu_badfun flags %b fun %h exp %b %h", flags, ALU_FUN, 5'b00010, 4'h7);
        end
        idle_cycle();
    endtask

    task automatic test_errors();
        send_byte(8'hAA);
        send_byte(8'h02);
        RX_PAR_ERR = 1'b1;
        idle_cycle();
        checks++;
        if (flags !== 5'b00010) begin
            errors++; $display("FAIL par_abort flags got %b exp %b", flags, 5'b00010);
        end
        idle_cycle();
        checks++;
        if (flags !== 5'b00000) begin
            errors++; $display("FAIL par_hold1 flags got %b exp %b", flags, 5'b00000);
        end
        idle_cycle();
        checks++;
        if (flags !== 5'b00000) begin
            errors++; $display("FAIL par_hold2 flags got %b exp %b", flags, 5'b00000);
        end
        RX_PAR_ERR = 1'b0;
        // Flagged opcode in IDLE: discarded silently.
        RX_FRM_ERR = 1'b1;
        send_byte(8'hAA);
        RX_FRM_ERR = 1'b0;
        checks++;
        if (flags !== 5'b00000) begin
            errors++; $display("FAIL frm_idle flags got %b exp %b", flags, 5'b00000);
        end
        // Flagged byte mid-command: aborts, byte not used.
        send_byte(8'hBB);
        RX_FRM_ERR = 1'b1;
        send_byte(8'h03);
        RX_FRM_ERR = 1'b0;
        checks++;
        if (flags !== 5'b00010 || RF_Address !== 4'h1) begin
            errors++; $display("FAIL frm_abort flags %b addr %h exp %b %h", flags, RF_Address, 5'b00010, 4'h1);
        end
        send_byte(8'h55);
        checks++;
        if (flags !== 5'b00010) begin
            errors++; $display("FAIL bad_opcode flags got %b exp %b", flags, 5'b00010);
        end
        send_byte(8'hBB);
        send_byte(8'h01);
        checks++;
        if (flags !== 5'b01000 || RF_Address !== 4'h1) begin
            errors++; $display("FAIL rd_after_bad flags %b addr %h exp %b %h", flags, RF_Address, 5'b01000, 4'h1);
        end
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        send_byte(8'hAA);
        send_byte(8'h01);
        RST = 1'b0;
        idle_cycle();
        checks++;
        if (flags !== 5'b00000) begin
            errors++; $display("FAIL rst_mid_flags got %b exp %b", flags, 5'b00000);
        end
        checks++;
        if ({RF_Address, RF_WrData, ALU_FUN} !== 16'h0000) begin
            errors++; $display("FAIL rst_mid_fields got %h exp %h", {RF_Address, RF_WrData, ALU_FUN}, 16'h0000);
        end
        RST = 1'b1;
        idle_cycle();
        // A surviving WR_DATA state would turn this read into a write.
        send_byte(8'hBB);
        send_byte(8'h02);
        checks++;
        if (flags !== 5'b01000 || RF_Address !== 4'h2) begin
            errors++; $display("FAIL rst_mid_read flags %b addr %h exp %b %h", flags, RF_Address, 5'b01000, 4'h2);
        end
        idle_cycle();
    endtask

    task automatic test_timeout();
`ifdef RX_CMD_TIMEOUT_EN
        int waited;
        waited = 0;
        send_byte(8'hCC);
        for (int k = 1; k <= 40; k++) begin
            idle_cycle();
            if (CMD_ERR === 1'b1) begin
                waited = k;
                break;
            end
        end
        checks++;
        if (waited != TIMEOUT_CYCLES) begin
            errors++; $display("FAIL timeout_latency got %0d exp %0d", waited, TIMEOUT_CYCLES);
        end
        checks++;
        if (flags !== 5'b00010) begin
            errors++; $display("FAIL timeout_flags got %b exp %b", flags, 5'b00010);
        end
        idle_cycle();
`else
        send_byte(8'hCC);
        repeat (30) idle_cycle();
        checks++;
        if (flags !== 5'b00001) begin
            errors++; $display("FAIL no_timeout_wait flags got %b exp %b", flags, 5'b00001);
        end
        send_byte(8'h5A);
        checks++;
        if (flags !== 5'b10001 || {RF_Address, RF_WrData} !== 12'h05A) begin
            errors++; $display("FAIL no_timeout_opa flags %b fields %h exp %b %h", flags, {RF_Address, RF_WrData}, 5'b10001, 12'h05A);
        end
        RX_PAR_ERR = 1'b1;
        idle_cycle();
        RX_PAR_ERR = 1'b0;
        checks++;
        if (flags !== 5'b00010) begin
            errors++; $display("FAIL no_timeout_abort flags got %b exp %b", flags, 5'b00010);
        end
        idle_cycle();
`endif
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_write();
        test_read();
        test_back_to_back_alu();
        test_errors();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_cmd_parser.md
# rx_cmd_parser

Command-frame parser downstream of the UART receiver: consumes validated 8-bit bytes plus parity/framing error flags and assembles them into register-file read/write and ALU commands. Emits single-cycle command strobes with held address, data and function fields toward the register file and the ALU. Sits in the system-controller receive path, in the same clock domain as the UART receiver output.

## Interface
- DATA_WIDTH, 8: received byte and register write-data width
- ADDR_WIDTH, 4: register-file address width
- TIMEOUT_CYCLES, 1024: inter-byte timeout in CLK cycles (used only with RX_CMD_TIMEOUT_EN)

- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous, active-low reset
- RX_P_DATA  in  DATA_WIDTH  received byte
- RX_D_VLD  in  1  single-cycle strobe, RX_P_DATA valid
- RX_PAR_ERR  in  1  parity error flag from receiver
- RX_FRM_ERR  in  1  framing error flag from receiver
- RF_WrEn  out  1  register write strobe, one cycle
- RF_RdEn  out  1  register read strobe, one cycle
- RF_Address  out  ADDR_WIDTH  register address, held
- RF_WrData  out  DATA_WIDTH  register write data, held
- ALU_EN  out  1  ALU operation strobe, one cycle
- ALU_FUN  out  4  ALU function code, held
- CMD_BUSY  out  1  high while a command is partially assembled (state ≠ IDLE)
- CMD_ERR  out  1  one-cycle pulse on aborted or illegal command

## Operation
- Opcodes: 0xAA write (ADDR, DATA); 0xBB read (ADDR); 0xCC ALU with operands (OPA, OPB, FUN); 0xDD ALU without operands (FUN).
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_OPA, ALU_OPB, ALU_FUN.
- IDLE + byte: AA→WR_ADDR, BB→RD_ADDR, CC→ALU_OPA, DD→ALU_FUN. Any other opcode: CMD_ERR pulse, stay IDLE.
- WR_ADDR: latch address →WR_DATA. WR_DATA: RF_WrEn, RF_WrData=byte →IDLE.
- RD_ADDR: RF_RdEn, RF_Address=byte →IDLE.
- ALU_OPA: RF_WrEn, addr 0, data=byte →ALU_OPB.
- ALU_OPB: RF_WrEn, addr 1, data=byte →ALU_FUN.
- ALU_FUN: ALU_EN, ALU_FUN=byte[3:0] →IDLE.
- Illegal field: an address byte ≥ 2^ADDR_WIDTH, or a FUN byte with a nonzero upper nibble, causes CMD_ERR, no strobe, and a return to IDLE.
- Error flags: while not in IDLE, RX_PAR_ERR or RX_FRM_ERR high aborts the command (CMD_ERR, →IDLE). A byte whose RX_D_VLD coincides with either flag is discarded in every state. Flags in IDLE produce no CMD_ERR. Persistent flags give only one CMD_ERR.
- RX_D_VLD on consecutive cycles counts as separate bytes.

## Timing
- Reset values: all strobes 0, CMD_BUSY 0, CMD_ERR 0, RF_Address 0, RF_WrData 0, ALU_FUN 0; state IDLE.
- All outputs are registered. A strobe or CMD_ERR asserts exactly one cycle after the RX_D_VLD cycle of the triggering byte.
- RF_Address, RF_WrData and ALU_FUN update in the same cycle as their strobe. They then hold until the next strobe.
- At most one of RF_WrEn, RF_RdEn, ALU_EN is high per cycle. CMD_ERR never coincides with a strobe.
- A new opcode may arrive the cycle after a completing byte, with no gap required.
- Reset mid-command: the partial command is discarded with no strobe and no CMD_ERR.

## Configuration
- RX_CMD_TIMEOUT_EN defined:
  - A counter runs while the state is not IDLE and clears on every accepted byte.
  - When it reaches TIMEOUT_CYCLES, the block pulses CMD_ERR and returns to IDLE.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined: no counter; a partial command waits indefinitely.

## Structure
- Shared package holds:
  - the opcode constants (0xAA, 0xBB, 0xCC, 0xDD)
  - the state enum typedef
  - the operand register addresses (OPA_ADDR=0, OPB_ADDR=1)
- One sub-module, rx_cmd_timeout: the counter with clear and enable inputs and an expire output. It is instantiated only under RX_CMD_TIMEOUT_EN.

## Test plan
- Write: bytes AA, 05, 3C → RF_WrEn for one cycle with RF_Address=5 and RF_WrData=0x3C, one cycle after the last RX_D_VLD; CMD_BUSY low afterwards.
- Read: bytes BB, 0F → RF_RdEn for one cycle with RF_Address=0xF; byte BB, 10 → CMD_ERR, no RF_RdEn.
- ALU sequence: bytes CC, 12, 34, 03 → RF_WrEn at addr 0 with 0x12, then RF_WrEn at addr 1 with 0x34, then ALU_EN with ALU_FUN=3. Bytes DD, 07 → ALU_EN with ALU_FUN=7.
- Errors, first case: bytes AA, 02, then RX_PAR_ERR held for 3 cycles → a single CMD_ERR, no RF_WrEn.
- Errors, second case: opcode 0x55 → CMD_ERR, state stays IDLE. The next sequence BB, 01 still completes normally.
- Timeout and reset:
  - With RX_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16: byte CC then silence → CMD_ERR 16 cycles later.
  - RST low after AA, 01 → no strobe, all outputs at 0.
